// File: rtl/fwpayload_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fwpayload_wb_arbiter_if
// Purpose  : Classic single-beat Wishbone bundle. Used for the two initiator
//            ports and the target port of fwpayload_wb_arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface fwpayload_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    we;
    logic                    cyc;
    logic                    stb;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic                    ack;

    // Side that issues requests
    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack
    );

    // Side that answers requests
    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack
    );
endinterface
`default_nettype wire

// File: rtl/fwpayload_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fwpayload_wb_arbiter
// Purpose  : Two-initiator classic Wishbone arbiter in front of the fwpayload
//            slave port. Round-robin, grant locked for a whole cyc, with a
//            watchdog that force-acks stalled transfers.
// Revision : 1.0  initial release
// ============================================================================
module fwpayload_wb_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    fwpayload_wb_arbiter_if.slave  i0,
    fwpayload_wb_arbiter_if.slave  i1,
    fwpayload_wb_arbiter_if.master t,
    output logic [1:0]            gnt,
    output logic                  timeout
);

    // Counter only needs to hold up to TIMEOUT-1: reaching the limit moves
    // the FSM to TOUT, which clears it.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_limit = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit c_wd_en = (TIMEOUT > 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GNT0 = 2'd1;
    localparam logic [1:0] S_GNT1 = 2'd2;
    localparam logic [1:0] S_TOUT = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic          r_last;        // initiator that held the previous grant
    logic          w_last_next;
    logic          r_owner;       // initiator owning GNTn / TOUT
    logic          w_owner_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    // Request of the current owner, muxed once for both GNT states
    logic                    w_cur_cyc;
    logic                    w_cur_stb;
    logic                    w_oth_cyc;
    logic [ADDR_WIDTH-1:0]   w_req_adr;
    logic [DATA_WIDTH-1:0]   w_req_dat;
    logic [DATA_WIDTH/8-1:0] w_req_sel;
    logic                    w_req_we;
    logic                    w_wd_hit;

    assign w_cur_cyc = r_owner ? i1.cyc : i0.cyc;
    assign w_cur_stb = w_cur_cyc & (r_owner ? i1.stb : i0.stb);
    assign w_oth_cyc = r_owner ? i0.cyc : i1.cyc;
    assign w_req_adr = r_owner ? i1.adr   : i0.adr;
    assign w_req_dat = r_owner ? i1.dat_w : i0.dat_w;
    assign w_req_sel = r_owner ? i1.sel   : i0.sel;
    assign w_req_we  = r_owner ? i1.we    : i0.we;

    // A target ack in the limit cycle wins over the watchdog.
    assign w_wd_hit = c_wd_en && w_cur_stb && !t.ack && (r_cnt == c_limit);

    // State, round-robin memory, owner and watchdog counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
            r_owner <= w_owner_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state: arbitration, cyc-drop handover and watchdog
    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        w_owner_next = r_owner;
        w_cnt_next   = '0;
        case (r_state)
            S_IDLE: begin
                if (i0.cyc && (!i1.cyc || r_last)) begin
                    w_state_next = S_GNT0;
                    w_owner_next = 1'b0;
                end else if (i1.cyc) begin
                    w_state_next = S_GNT1;
                    w_owner_next = 1'b1;
                end
            end
            S_GNT0, S_GNT1: begin
                if (!w_cur_cyc) begin
                    w_last_next = r_owner;
                    if (w_oth_cyc) begin
                        w_state_next = r_owner ? S_GNT0 : S_GNT1;
                        w_owner_next = ~r_owner;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else if (w_wd_hit) begin
                    w_state_next = S_TOUT;
                end else if (t.ack) begin
                    w_cnt_next = '0;
                end else if (w_cur_stb) begin
                    w_cnt_next = r_cnt + CW'(1);
                end else begin
                    w_cnt_next = r_cnt;
                end
            end
            S_TOUT: begin
                if (w_cur_cyc) begin
                    w_state_next = r_owner ? S_GNT1 : S_GNT0;
                end else begin
                    w_last_next = r_owner;
                    if (w_oth_cyc) begin
                        w_state_next = r_owner ? S_GNT0 : S_GNT1;
                        w_owner_next = ~r_owner;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs: request/return routing from the registered state only
    always_comb begin
        t.adr    = '0;
        t.dat_w  = '0;
        t.sel    = '0;
        t.we     = 1'b0;
        t.cyc    = 1'b0;
        t.stb    = 1'b0;
        i0.ack   = 1'b0;
        i0.dat_r = '0;
        i1.ack   = 1'b0;
        i1.dat_r = '0;
        gnt      = 2'b00;
        timeout  = 1'b0;
        case (r_state)
            S_GNT0, S_GNT1: begin
                t.adr   = w_req_adr;
                t.dat_w = w_req_dat;
                t.sel   = w_req_sel;
                t.we    = w_req_we;
                t.cyc   = w_cur_cyc;
                t.stb   = w_cur_stb;
                if (r_owner) begin
                    i1.ack   = t.ack;
                    i1.dat_r = t.dat_r;
                    gnt      = 2'b10;
                end else begin
                    i0.ack   = t.ack;
                    i0.dat_r = t.dat_r;
                    gnt      = 2'b01;
                end
            end
            S_TOUT: begin
                timeout = 1'b1;
                if (r_owner) begin
                    i1.ack   = 1'b1;
                    i1.dat_r = '1;
                    gnt      = 2'b10;
                end else begin
                    i0.ack   = 1'b1;
                    i0.dat_r = '1;
                    gnt      = 2'b01;
                end
            end
            default: begin
                gnt = 2'b00;
            end
        endcase
    end

endmodule
`default_nettype wire
